// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions for the ALU-sharing arbiter and the ALU itself.
// Contents: ALU op codes, arbiter FSM state type, legal-op check.
package alu_share_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// ALU: combinational 32-bit ALU shared by the arbiter.
// Ports:
//   op     - operation code (AND, OR, ADD, SUB, signed SLT)
//   a, b   - operands
//   result - operation result; 0 for illegal op codes
//   zero   - high when result is all zeros
module ALU
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters with round-robin
// priority. A grant captures the operands, the ALU runs for one cycle, then a
// registered result/zero/err is presented with a one-cycle done pulse.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req0/req1         - requests, held until granted
//   op0/op1, a*/b*    - per-requester op code and operands
//   gnt0/gnt1         - combinational accept, only in IDLE
//   done0/done1       - one-cycle completion pulse for the served requester
//   result, zero, err - registered ALU outputs, held until the next EXEC
//   busy              - high whenever the arbiter is not IDLE
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             busy
);

  state_t           state;
  logic             last_id;
  logic             id_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             pick1;
  logic             idle;

  // Requester 1 wins when alone, or when both ask and 0 was served last.
  assign pick1 = req1 & (~req0 | ~last_id);
  // Reset gates the grants since the state decode alone reads as IDLE.
  assign idle  = (state == ST_IDLE) & ~rst;
  assign gnt1  = idle & pick1;
  assign gnt0  = idle & req0 & ~pick1;
  assign busy  = (state != ST_IDLE);

  ALU #(.WIDTH(WIDTH)) u_alu (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      last_id <= 1'b1;
      id_r    <= 1'b0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      err     <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt0 | gnt1) begin
            op_r    <= gnt1 ? op1 : op0;
            a_r     <= gnt1 ? a1 : a0;
            b_r     <= gnt1 ? b1 : b0;
            id_r    <= gnt1;
            last_id <= gnt1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result <= alu_result;
          zero   <= alu_zero;
          err    <= ~is_legal_op(op_r);
          // Registered here so the pulse coincides exactly with DONE.
          done0  <= ~id_r;
          done1  <= id_r;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, zero, err, busy;
  logic [31:0] result;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .result(result), .zero(zero), .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: cycles remaining in the current transaction
  // (2 = executing, 1 = completing, 0 = free) plus the captured job.
  int          m_left;
  bit          m_last, m_id;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic        m_zero, m_err;

  // observations
  logic        last_g0, last_g1, seen_done, s_id, s_zero, s_err, s_gnt;
  logic [31:0] s_res;
  typedef struct { bit id; logic [31:0] res; logic z; logic e; } done_t;
  done_t dq[$];
  bit    gq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd6: return a - b;
      3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_last = 1; m_id = 0;
    m_res = '0; m_zero = 0; m_err = 0;
  endtask

  // One clock: compare at negedge, advance model across the posedge.
  task automatic step();
    logic e_g0, e_g1, e_d0, e_d1;
    @(negedge clk);
    e_g0 = 0; e_g1 = 0;
    if (m_left == 0) begin
      e_g1 = req1 && (!req0 || m_last == 0);
      e_g0 = req0 && !e_g1;
    end
    e_d0 = (m_left == 1) && (m_id == 0);
    e_d1 = (m_left == 1) && (m_id == 1);
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("busy", busy, m_left != 0);
    chk("done0", done0, e_d0);
    chk("done1", done1, e_d1);
    chk("result", result, m_res);
    chk("zero", zero, m_zero);
    chk("err", err, m_err);
    last_g0 = gnt0; last_g1 = gnt1;
    if (done0 || done1) begin
      seen_done = 1; s_id = done1; s_res = result; s_zero = zero; s_err = err;
      s_gnt = gnt0 | gnt1;
      dq.push_back('{done1, result, zero, err});
    end
    if (gnt0 || gnt1) gq.push_back(gnt1);
    if (m_left == 2) begin
      m_res  = ref_alu(m_op, m_a, m_b);
      m_zero = (m_res == 0);
      m_err  = (m_op == 3 || m_op == 4 || m_op == 5);
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (e_g0 || e_g1) begin
      m_id = e_g1; m_last = e_g1;
      m_op = e_g1 ? op1 : op0;
      m_a  = e_g1 ? a1 : a0;
      m_b  = e_g1 ? b1 : b0;
      m_left = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done0, done1}, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_err", err, 0);
    model_reset();
    rst = 0;
  endtask

  task automatic wait_done(input string name, output int n);
    seen_done = 0; n = 0;
    while (!seen_done && n < 8) begin step(); n++; end
    chk({name, "_timeout"}, seen_done, 1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    model_reset();
    req0 = 1; // grant must stay low during reset even with a request
    do_reset();
    req0 = 0;

    // single request ADD 5+7
    op0 = 3'b010; a0 = 5; b0 = 7; req0 = 1;
    step();
    chk("t1_gnt0", last_g0, 1);
    req0 = 0;
    wait_done("t1", n);
    chk("t1_latency", n, 2);
    chk("t1_id", s_id, 0);
    chk("t1_result", s_res, 12);
    chk("t1_zero", s_zero, 0);
    chk("t1_err", s_err, 0);

    // both held: alternation and SUB/SLT values
    do_reset();
    op0 = 3'b110; a0 = 9; b0 = 9;
    op1 = 3'b111; a1 = 32'hFFFFFFFF; b1 = 1;
    req0 = 1; req1 = 1;
    dq.delete(); gq.delete();
    repeat (12) step();
    req0 = 0; req1 = 0;
    chk("t2_ndone", dq.size(), 4);
    chk("t2_ngnt", gq.size(), 4);
    if (dq.size() >= 2 && gq.size() >= 4) begin
      chk("t2_d0_id", dq[0].id, 0);
      chk("t2_d0_res", dq[0].res, 0);
      chk("t2_d0_zero", dq[0].z, 1);
      chk("t2_d1_id", dq[1].id, 1);
      chk("t2_d1_res", dq[1].res, 1);
      chk("t2_gseq", {gq[0], gq[1], gq[2], gq[3]}, 4'b0101);
    end
    step();

    // illegal op
    op1 = 3'b100; a1 = 32'hFFFF; b1 = 32'hFFFF; req1 = 1;
    step();
    req1 = 0;
    wait_done("t3", n);
    chk("t3_id", s_id, 1);
    chk("t3_result", s_res, 0);
    chk("t3_zero", s_zero, 1);
    chk("t3_err", s_err, 1);

    // reset during EXEC
    op0 = 3'b010; a0 = 1; b0 = 1; req0 = 1;
    step();
    chk("t4_busy_exec", busy, 1);
    rst = 1;
    #1;
    chk("t4_async_busy", busy, 0);
    chk("t4_async_done", {done0, done1}, 0);
    req1 = 1;
    do_reset();
    a0 = 2; b0 = 3;
    step();
    chk("t4_gnt0_first", last_g0, 1);
    chk("t4_gnt1_not", last_g1, 0);
    req0 = 0; req1 = 0;
    wait_done("t4", n);
    chk("t4_id", s_id, 0);
    chk("t4_result", s_res, 5);

    // req1 held through DONE
    step();
    op1 = 3'b001; a1 = 32'hF0; b1 = 32'h0F; req1 = 1;
    step();
    wait_done("t5", n);
    chk("t5_no_gnt_in_done", s_gnt, 0);
    step();
    chk("t5_gnt1_after", last_g1, 1);
    req1 = 0;
    step(); step();

    // operand change after grant
    op0 = 3'b001; a0 = 3; b0 = 4; req0 = 1;
    step();
    req0 = 0; a0 = 100;
    wait_done("t6", n);
    chk("t6_result", s_res, 7);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if (!(req0 && !last_g0 && $urandom_range(0, 7) != 0)) req0 = $urandom_range(0, 1);
      if (!(req1 && !last_g1 && $urandom_range(0, 7) != 0)) req1 = $urandom_range(0, 1);
      op0 = $urandom_range(0, 7); op1 = $urandom_range(0, 7);
      a0 = rnd_operand(); b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd_operand();
      a1 = rnd_operand(); b1 = ($urandom_range(0, 3) == 0) ? a1 : rnd_operand();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
